// File: rtl/apb3_requester.sv
// Single-outstanding APB3 requester: turns a valid/ready command stream into
// SETUP/ACCESS transfers and returns each completion on a valid/ready response channel.
module apb3_requester #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  // A zero TIMEOUT still needs a one-bit counter so the design elaborates.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    wait_q, wait_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic                wait_expired;

  assign wait_expired = (TIMEOUT > 0) && (wait_q == WAIT_LAST);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      wait_q        <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_addr[1:0] == 2'b00) begin
            pwrite_d  = cmd_write;
            paddr_d   = cmd_addr;
            pwdata_d  = cmd_wdata;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            wait_d    = '0;
            state_d   = SETUP;
          end else begin
            // Misaligned commands never reach the bus; they complete as an error.
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
            state_d       = RESP;
          end
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (wait_expired) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          pwrite_d    = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == IDLE);
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb3_requester.sv
// Self-checking bench for apb3_requester: plays an APB completer and scores
// each response against an expectation queued when the command is issued.
module tb_apb3_requester;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              PCLK = 1'b0;
  logic              PRESETn = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              PSEL, PENABLE, PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA = '0;
  logic              PREADY = 1'b0;
  logic              PSLVERR = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  rsp_t expQ[$];

  always #5 PCLK = ~PCLK;

  apb3_requester #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge PCLK);
    #1;
  endtask

  // One full command: issue it, act as the completer, then drain the response.
  task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                               input int waits, input logic [31:0] rdata, input logic slverr,
                               input int rspDelay);
    rsp_t e;
    logic aligned;
    aligned = (addr[1:0] == 2'b00);
    if (!aligned) begin
      e.rdata = 32'h0; e.err = 1'b1; e.tmo = 1'b0;
    end else if (waits >= TIMEOUT) begin
      e.rdata = 32'h0; e.err = 1'b1; e.tmo = 1'b1;
    end else begin
      e.rdata = wr ? 32'h0 : rdata; e.err = slverr; e.tmo = 1'b0;
    end
    expQ.push_back(e);

    checkOutput("cmdReadyIdle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    step;
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = addr ^ 8'hF0; cmd_wdata = ~wdata;

    if (!aligned) begin
      checkOutput("misPsel", 32'(PSEL), 32'd0);
    end else begin
      checkOutput("setupPsel", 32'(PSEL), 32'd1);
      checkOutput("setupPenable", 32'(PENABLE), 32'd0);
      checkOutput("setupPaddr", 32'(PADDR), 32'(addr));
      checkOutput("setupPwdata", PWDATA, wdata);
      checkOutput("setupPwrite", 32'(PWRITE), 32'(wr));
      checkOutput("setupRspValid", 32'(rsp_valid), 32'd0);
      checkOutput("setupCmdReady", 32'(cmd_ready), 32'd0);
      step;
      for (int i = 0; i < TIMEOUT + 4; i++) begin
        checkOutput("accPsel", 32'(PSEL), 32'd1);
        checkOutput("accPenable", 32'(PENABLE), 32'd1);
        checkOutput("accPaddr", 32'(PADDR), 32'(addr));
        checkOutput("accPwdata", PWDATA, wdata);
        checkOutput("accPwrite", 32'(PWRITE), 32'(wr));
        checkOutput("accRspValid", 32'(rsp_valid), 32'd0);
        PREADY  = (i == waits);
        PRDATA  = rdata;
        PSLVERR = (i == waits) ? slverr : 1'b1;
        step;
        if (i == waits || i == TIMEOUT - 1) break;
      end
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
      checkOutput("endPsel", 32'(PSEL), 32'd0);
      checkOutput("endPenable", 32'(PENABLE), 32'd0);
    end

    checkOutput("rspValid", 32'(rsp_valid), 32'd1);
    for (int d = 0; d < rspDelay; d++) begin
      rsp_ready = 1'b0;
      checkOutput("holdRspValid", 32'(rsp_valid), 32'd1);
      checkOutput("holdRdata", rsp_rdata, e.rdata);
      checkOutput("holdErr", 32'(rsp_err), 32'(e.err));
      checkOutput("holdTmo", 32'(rsp_timeout), 32'(e.tmo));
      checkOutput("holdCmdReady", 32'(cmd_ready), 32'd0);
      checkOutput("holdPsel", 32'(PSEL), 32'd0);
      step;
    end

    rsp_ready = 1'b1;
    checkOutput("sbNotEmpty", 32'(expQ.size() > 0), 32'd1);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("rspRdata", rsp_rdata, e.rdata);
      checkOutput("rspErr", 32'(rsp_err), 32'(e.err));
      checkOutput("rspTmo", 32'(rsp_timeout), 32'(e.tmo));
    end
    step;
    rsp_ready = 1'b0;
    checkOutput("postRspValid", 32'(rsp_valid), 32'd0);
    checkOutput("postCmdReady", 32'(cmd_ready), 32'd1);
    checkOutput("postPwrite", 32'(PWRITE), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] stopped by watchdog");
  end

  initial begin
    #2;
    checkOutput("rstPsel", 32'(PSEL), 32'd0);
    checkOutput("rstPenable", 32'(PENABLE), 32'd0);
    checkOutput("rstPwrite", 32'(PWRITE), 32'd0);
    checkOutput("rstPaddr", 32'(PADDR), 32'd0);
    checkOutput("rstPwdata", PWDATA, 32'd0);
    checkOutput("rstRspValid", 32'(rsp_valid), 32'd0);
    checkOutput("rstRdata", rsp_rdata, 32'd0);
    checkOutput("rstErr", 32'(rsp_err), 32'd0);
    checkOutput("rstTmo", 32'(rsp_timeout), 32'd0);
    checkOutput("rstCmdReady", 32'(cmd_ready), 32'd1);
    @(negedge PCLK);
    PRESETn = 1'b1;
    step;

    applyStimulus(1'b1, 8'h0C, 32'h0000_00A5, 0,   32'hFFFF_0000, 1'b0, 0);
    applyStimulus(1'b0, 8'h08, 32'h1111_2222, 3,   32'h0000_0041, 1'b0, 1);
    applyStimulus(1'b1, 8'h04, 32'h0000_5A5A, 0,   32'h0000_0000, 1'b1, 0);
    applyStimulus(1'b0, 8'h20, 32'h0000_0000, 100, 32'hDEAD_BEEF, 1'b0, 0);
    applyStimulus(1'b1, 8'h06, 32'h0BAD_0BAD, 0,   32'h0000_0000, 1'b0, 5);
    applyStimulus(1'b0, 8'h03, 32'h0000_0000, 0,   32'h0000_0000, 1'b0, 0);
    applyStimulus(1'b0, 8'h1C, 32'h0000_0000, 1,   32'hCAFE_F00D, 1'b0, 2);
    applyStimulus(1'b0, 8'h24, 32'h0000_0000, 15,  32'h0000_7777, 1'b1, 0);

    // Reset in the middle of a waited read.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h08; cmd_wdata = 32'h0;
    step;
    cmd_valid = 1'b0;
    step;
    PREADY = 1'b0;
    step;
    step;
    checkOutput("midPsel", 32'(PSEL), 32'd1);
    #2;
    PRESETn = 1'b0;
    #1;
    checkOutput("asyncPsel", 32'(PSEL), 32'd0);
    checkOutput("asyncPenable", 32'(PENABLE), 32'd0);
    checkOutput("asyncRspValid", 32'(rsp_valid), 32'd0);
    checkOutput("asyncCmdReady", 32'(cmd_ready), 32'd1);
    @(negedge PCLK);
    PRESETn = 1'b1;
    step;
    applyStimulus(1'b1, 8'h10, 32'h1234_5678, 0, 32'h0000_0000, 1'b0, 0);

    checkOutput("sbEmpty", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
